// File: rtl/toggle_counter_pkg.sv
// rtl/toggle_counter_pkg.sv - shared mode enum and width limit for toggle_counter
package toggle_counter_pkg;

    // Boundary behaviour when the count reaches MAX_COUNT (up) or 0 (down)
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    // Widest counter the block may be configured for
    localparam int unsigned CNT_MAX_WIDTH = 32;

    // Binary to reflected Gray code
    function automatic logic [CNT_MAX_WIDTH-1:0] bin_to_gray(input logic [CNT_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/toggle_bit.sv
// rtl/toggle_bit.sv - falling-edge T flip-flop with async reset and sync clear/load
module toggle_bit (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clear_in,
    input  logic load_in,
    input  logic load_val_in,
    input  logic t_in,
    output logic q_out
);

    logic q_d;
    logic q_q;

    // Next bit value: clear wins over load, load wins over toggle
    always_comb begin
        q_d = q_q;
        if (clear_in) begin
            q_d = 1'b0;
        end else if (load_in) begin
            q_d = load_val_in;
        end else if (t_in) begin
            q_d = ~q_q;
        end
    end

    // Bit state, forced low immediately while reset is high
    always_ff @(negedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out = q_q;

endmodule

// File: rtl/toggle_counter.sv
// rtl/toggle_counter.sv - up/down wrap/saturate counter built from T flip-flops; optional gray_out with TOGGLE_COUNTER_GRAY_EN
module toggle_counter
    import toggle_counter_pkg::*;
#(
    parameter int unsigned                WIDTH     = 8,
    parameter logic [CNT_MAX_WIDTH:0]     MAX_COUNT = (33'd1 << WIDTH) - 33'd1,
    parameter cnt_mode_e                  MODE      = MODE_WRAP
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             en_in,
    input  logic             up_in,
    input  logic             clear_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_out,
    output logic             ovf_out
`ifdef TOGGLE_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray_out
`endif
);

    if (WIDTH < 2 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
        $error("toggle_counter: WIDTH must be in 2..32");
    end
    if (MAX_COUNT < 33'd1 || MAX_COUNT > ((33'd1 << WIDTH) - 33'd1)) begin : g_bad_max
        $error("toggle_counter: MAX_COUNT must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_W = MAX_COUNT[WIDTH-1:0];

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] chain_up;
    logic [WIDTH-1:0] chain_dn;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic             ovf_d;
    logic             ovf_q;

    // Loads above the terminal value are clamped so count never exceeds MAX_COUNT
    always_comb begin
        load_clamped = (load_val_in > MAX_W) ? MAX_W : load_val_in;
    end

    // Terminal-count strobe: an enabled step that would cross the boundary this edge
    always_comb begin
        tc = en_in & ~clear_in & ~load_in &
             ((up_in & (count == MAX_W)) | (~up_in & (count == '0)));
    end

    // Carry chain (all lower bits 1) for up, borrow chain (all lower bits 0) for down
    always_comb begin
        chain_up    = '0;
        chain_dn    = '0;
        chain_up[0] = 1'b1;
        chain_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            chain_up[i] = chain_up[i-1] & count[i-1];
            chain_dn[i] = chain_dn[i-1] & ~count[i-1];
        end
    end

    // Per-bit toggle enables; at the boundary toggle straight to the wrap target or not at all
    always_comb begin
        t_vec = '0;
        if (en_in) begin
            if (tc) begin
                if (MODE == MODE_WRAP) begin
                    t_vec = up_in ? count : MAX_W;
                end else begin
                    t_vec = '0;
                end
            end else begin
                t_vec = up_in ? chain_up : chain_dn;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        toggle_bit u_bit (
            .clk_in      (clk_in),
            .reset_in    (reset_in),
            .clear_in    (clear_in),
            .load_in     (load_in),
            .load_val_in (load_clamped[i]),
            .t_in        (t_vec[i]),
            .q_out       (count[i])
        );
    end

    // Sticky boundary flag: set by any terminal step, cleared only by clear
    always_comb begin
        ovf_d = ovf_q;
        if (clear_in) begin
            ovf_d = 1'b0;
        end else if (tc) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(negedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign count_out = count;
    assign tc_out    = tc;
    assign ovf_out   = ovf_q;

`ifdef TOGGLE_COUNTER_GRAY_EN
    logic [WIDTH-1:0]         count_d;
    logic [CNT_MAX_WIDTH-1:0] count_d_ext;
    logic [CNT_MAX_WIDTH-1:0] gray_ext;
    logic [WIDTH-1:0]         gray_d;
    logic [WIDTH-1:0]         gray_q;

    // Next count value, encoded so gray_q tracks count_out on the same edge
    always_comb begin
        if (clear_in) begin
            count_d = '0;
        end else if (load_in) begin
            count_d = load_clamped;
        end else begin
            count_d = count ^ t_vec;
        end
        count_d_ext              = '0;
        count_d_ext[WIDTH-1:0]   = count_d;
        gray_ext                 = bin_to_gray(count_d_ext);
        gray_d                   = gray_ext[WIDTH-1:0];
    end

    // Gray output register
    always_ff @(negedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign gray_out = gray_q;
`endif

endmodule

// File: tb/tb_toggle_counter.sv
// tb/tb_toggle_counter.sv - randomized and directed checks of toggle_counter in wrap and saturate modes
module tb_toggle_counter;
    import toggle_counter_pkg::*;

    localparam int MAXC = 9;

    logic       clk = 1'b1;
    logic       reset_in;
    logic       en_in;
    logic       up_in;
    logic       clear_in;
    logic       load_in;
    logic [3:0] load_val_in;

    logic [3:0] count_w, count_s;
    logic       tc_w, tc_s, ovf_w, ovf_s;
`ifdef TOGGLE_COUNTER_GRAY_EN
    logic [3:0] gray_w, gray_s;
`endif

    int checks = 0;
    int errors = 0;
    bit active = 1'b0;

    // Reference state: plain integers, one set per mode
    int mw, ow, ms, os;

    always #5 clk = ~clk;

    toggle_counter #(.WIDTH(4), .MAX_COUNT(33'd9), .MODE(MODE_WRAP)) dut_wrap (
        .clk_in(clk), .reset_in(reset_in), .en_in(en_in), .up_in(up_in),
        .clear_in(clear_in), .load_in(load_in), .load_val_in(load_val_in),
        .count_out(count_w), .tc_out(tc_w), .ovf_out(ovf_w)
`ifdef TOGGLE_COUNTER_GRAY_EN
        , .gray_out(gray_w)
`endif
    );

    toggle_counter #(.WIDTH(4), .MAX_COUNT(33'd9), .MODE(MODE_SAT)) dut_sat (
        .clk_in(clk), .reset_in(reset_in), .en_in(en_in), .up_in(up_in),
        .clear_in(clear_in), .load_in(load_in), .load_val_in(load_val_in),
        .count_out(count_s), .tc_out(tc_s), .ovf_out(ovf_s)
`ifdef TOGGLE_COUNTER_GRAY_EN
        , .gray_out(gray_s)
`endif
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int model_tc(input int c);
        if (!en_in || clear_in || load_in) return 0;
        if (up_in && c == MAXC) return 1;
        if (!up_in && c == 0) return 1;
        return 0;
    endfunction

    task automatic model_step(inout int c, inout int o, input bit sat);
        if (clear_in) begin
            c = 0;
            o = 0;
        end else if (load_in) begin
            c = (int'(load_val_in) > MAXC) ? MAXC : int'(load_val_in);
        end else if (en_in) begin
            if (up_in) begin
                if (c == MAXC) begin
                    o = 1;
                    c = sat ? MAXC : 0;
                end else begin
                    c = c + 1;
                end
            end else begin
                if (c == 0) begin
                    o = 1;
                    c = sat ? 0 : MAXC;
                end else begin
                    c = c - 1;
                end
            end
        end
    endtask

    // Compare process: state is stable and inputs settled 4 units after each rising edge
    always begin
        @(posedge clk);
        #4;
        if (active) begin
            chk("count_wrap", int'(count_w), mw);
            chk("ovf_wrap",   int'(ovf_w),   ow);
            chk("tc_wrap",    int'(tc_w),    model_tc(mw));
            chk("count_sat",  int'(count_s), ms);
            chk("ovf_sat",    int'(ovf_s),   os);
            chk("tc_sat",     int'(tc_s),    model_tc(ms));
`ifdef TOGGLE_COUNTER_GRAY_EN
            chk("gray_wrap",  int'(gray_w),  mw ^ (mw >> 1));
            chk("gray_sat",   int'(gray_s),  ms ^ (ms >> 1));
`endif
        end
    end

    task automatic drive(input bit c, input bit l, input int lv, input bit e, input bit u);
        @(posedge clk);
        #1;
        clear_in    = c;
        load_in     = l;
        load_val_in = lv[3:0];
        en_in       = e;
        up_in       = u;
    endtask

    task automatic edge_step();
        @(negedge clk);
        model_step(mw, ow, 1'b0);
        model_step(ms, os, 1'b1);
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        clear_in = 1'b0;
        load_in  = 1'b0;
        en_in    = 1'b0;
        reset_in = 1'b1;
        #1;
        chk("async_reset_count", int'(count_w), 0);
        chk("async_reset_ovf",   int'(ovf_w),   0);
        mw = 0; ow = 0; ms = 0; os = 0;
        #1;
        reset_in = 1'b0;
    endtask

`ifdef TOGGLE_COUNTER_GRAY_EN
    logic [3:0] gray_prev;
`endif

    initial begin
        reset_in = 1'b1;
        en_in = 1'b0; up_in = 1'b1; clear_in = 1'b0; load_in = 1'b0; load_val_in = '0;
        mw = 0; ow = 0; ms = 0; os = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", int'(count_w), 0);
        chk("reset_ovf",   int'(ovf_s),   0);
        #2;
        reset_in = 1'b0;
        active   = 1'b1;

        // Wrap up from 0: nine steps reach 9, tenth wraps to 0 and sets ovf
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 9; i++) begin
`ifdef TOGGLE_COUNTER_GRAY_EN
            gray_prev = gray_w;
`endif
            edge_step();
`ifdef TOGGLE_COUNTER_GRAY_EN
            chk("gray_one_bit_step", $countones(gray_prev ^ gray_w), 1);
`endif
        end
        chk("wrap_at_9", int'(count_w), 9);
        chk("wrap_tc_at_9", int'(tc_w), 1);
        chk("wrap_ovf_before", int'(ovf_w), 0);
        edge_step();
        chk("wrap_to_0", int'(count_w), 0);
        chk("wrap_ovf_set", int'(ovf_w), 1);
        chk("sat_hold_9", int'(count_s), 9);

        // Saturate down from 2
        drive(1, 0, 0, 0, 0);
        edge_step();
        drive(0, 1, 2, 0, 0);
        edge_step();
        chk("sat_load_2", int'(count_s), 2);
        drive(0, 0, 0, 1, 0);
        edge_step();
        chk("sat_down_1", int'(count_s), 1);
        edge_step();
        chk("sat_down_0", int'(count_s), 0);
        chk("sat_ovf_still_0", int'(ovf_s), 0);
        chk("sat_tc_at_0", int'(tc_s), 1);
        edge_step();
        chk("sat_hold_0", int'(count_s), 0);
        chk("sat_ovf_set", int'(ovf_s), 1);

        // Priority: clear beats load and enable; oversize load clamps
        drive(0, 1, 5, 0, 0);
        edge_step();
        chk("prio_load_5", int'(count_s), 5);
        drive(1, 1, 7, 1, 1);
        edge_step();
        chk("prio_clear_count", int'(count_s), 0);
        chk("prio_clear_ovf", int'(ovf_s), 0);
        drive(0, 1, 15, 0, 0);
        edge_step();
        chk("load_clamp_9", int'(count_w), 9);

        // Async reset between edges, then resume on the next falling edge
        drive(0, 1, 6, 0, 0);
        edge_step();
        chk("pre_reset_6", int'(count_w), 6);
        reset_pulse();
        drive(0, 0, 0, 1, 1);
        edge_step();
        chk("resume_after_reset", int'(count_w), 1);

        // Direction change: 3,2,1,0,9
        drive(1, 0, 0, 0, 0);
        edge_step();
        drive(0, 0, 0, 1, 1);
        repeat (3) edge_step();
        chk("dir_up_3", int'(count_w), 3);
        drive(0, 0, 0, 1, 0);
        edge_step();
        chk("dir_down_2", int'(count_w), 2);
        edge_step();
        edge_step();
        chk("dir_down_0", int'(count_w), 0);
        chk("dir_tc_at_0", int'(tc_w), 1);
        edge_step();
        chk("dir_wrap_9", int'(count_w), 9);

        // Randomized traffic checked by the compare process
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                  int'($urandom_range(15)), ($urandom_range(3) != 0), 1'($urandom_range(1)));
            edge_step();
            if ($urandom_range(63) == 0) reset_pulse();
        end

        @(posedge clk);
        #5;
        active = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
